gf180mcu_fd_sc_mcu7t5v0__clkdiv: RTL and testbench
==================================================

Name: gf180mcu_fd_sc_mcu7t5v0__clkdiv

Overview:
Programmable, glitch-free integer clock divider. It sits directly upstream of the clkbuf cells and drives the root of a divided clock tree. Z is always a registered output, so no combinational path exists from CLK to Z. Ratio changes and enable/disable take effect only at period boundaries, so no runt pulse ever reaches the buffer tree.

Parameters:
W, 4, width of divide-ratio field; supported ratio N ranges 2..2^W-1.
DIV_RST, 2, active ratio loaded at reset; must lie in 2..2^W-1.

Ports:
CLK  input  1  source clock; all state updates on the rising edge.
RN  input  1  asynchronous active-low reset.
EN  input  1  run request, synchronous to CLK.
LD  input  1  single-cycle strobe; captures DIV into the pending register.
DIV  input  W  requested divide ratio N; values 0 and 1 are clamped to 2.
Z  output  1  divided clock (registered) feeding the clock buffer.
ACT  output  1  high while the divider is producing pulses (RUN or STOPPING).
PEND  output  1  high while a captured ratio is waiting for a period boundary.

Behaviour:
- Reset (RN=0, async): Z=0, ACT=0, PEND=0, cnt=0, state=IDLE, active ratio NA=DIV_RST. All outputs clear immediately, independent of CLK. Release is synchronous to the next CLK edge; no pulse occurs before EN is seen.
- H = floor(NA/2) = high cycles; L = NA-H = low cycles. Example: NA=5 gives H=2, L=3; NA=2 gives H=1, L=1.
- Counter cnt runs 0..NA-1 in RUN/STOPPING. The Z register is loaded with (cnt_next < H), so Z is high for H edges, then low for L edges.
- Period boundary = the edge where cnt wraps NA-1 -> 0.
- States:
  IDLE: Z=0, ACT=0. When EN=1 is sampled: -> RUN, cnt=0, Z=1 at that same edge. On that edge NA loads the pending ratio if PEND=1, and PEND clears.
  RUN: count as above. On a boundary edge with EN=0 sampled: -> IDLE, Z stays 0. EN falling mid-period: -> STOPPING.
  STOPPING: finish the current period. At the boundary -> IDLE, with Z=0 and ACT=0 on that edge. If EN returns to 1 before the boundary, go back to RUN with no gap in the pulse train.
- Ratio update: LD=1 captures clamp(DIV) into the pending register; PEND=1 on the next edge.
  - At the next boundary, or at IDLE->RUN, NA takes the pending value and PEND clears on that edge.
  - The new period starts immediately with the new H/L.
- LD while PEND=1: the pending value is overwritten; only the last capture is applied.
- LD on the boundary edge itself: the old pending value (if any) is applied at this boundary. The new capture sets PEND for the following boundary.
- LD while IDLE: capture as normal; the value is applied on the next IDLE->RUN edge.
- NA never changes mid-period, so Z high/low widths are always exactly the H/L of a single ratio.
- ACT=1 exactly in RUN and STOPPING. It is registered, so it rises on the same edge as the first Z rise.

Test Plan:
- Reset, DIV_RST=2, EN=1 -> Z toggles every CLK edge (1,0,1,0...), ACT=1 from the first edge.
- LD with DIV=5 while IDLE, then EN=1 -> PEND=1 until the start edge. Z then repeats high 2, low 3; PEND=0.
- Running NA=5, LD DIV=3 at cnt=1 -> the current period completes as high 2, low 3. The next period is high 1, low 2. PEND is high from the edge after LD until the boundary edge.
- Running NA=4, EN dropped at cnt=1 -> high 2, low 2 completes, then Z=0 and ACT=0 at the boundary. EN reasserted at cnt=2 instead -> continuous 2/2 train with no gap.
- DIV=0 and DIV=1 loaded -> behaves as NA=2. LD twice (DIV=7, then DIV=6) before the boundary -> only NA=6 is applied (high 3, low 3).
- RN asserted mid high-phase with NA=6 -> Z=0, ACT=0, PEND=0 immediately, with no CLK edge needed. After release, NA=DIV_RST and the state is IDLE until EN.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv.sv
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu7t5v0__clkdiv
// Purpose : Programmable glitch-free integer clock divider with registered
//           output; ratio and run changes land only on period boundaries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__clkdiv #(
    parameter int W       = 4,
    parameter int DIV_RST = 2
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         EN,
    input  logic         LD,
    input  logic [W-1:0] DIV,
    output logic         Z,
    output logic         ACT,
    output logic         PEND
);

    localparam logic [W-1:0] NA_RST = W'(DIV_RST);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic [W-1:0] na;
    logic [W-1:0] na_next;
    logic [W-1:0] pend_val;
    logic [W-1:0] pend_val_next;
    logic [W-1:0] div_clamped;
    logic [W-1:0] high_cycles;
    logic         pend_next;
    logic         z_next;
    logic         act_next;
    logic         wrap;
    logic         apply;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        na_next       = na;
        apply         = 1'b0;
        div_clamped   = (DIV < W'(2)) ? W'(2) : DIV;
        wrap          = (cnt == (na - W'(1)));

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (EN) begin
                    state_next = RUN;
                    apply      = PEND;
                end
            end
            RUN, STOPPING: begin
                if (wrap) begin
                    cnt_next   = '0;
                    apply      = PEND;
                    state_next = EN ? RUN : IDLE;
                end else begin
                    cnt_next   = cnt + W'(1);
                    state_next = EN ? RUN : STOPPING;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // A pending ratio only ever lands at a period start, so widths never mix.
        if (apply) begin
            na_next = pend_val;
        end

        high_cycles   = na_next >> 1;
        act_next      = (state_next != IDLE);
        z_next        = act_next && (cnt_next < high_cycles);
        pend_next     = LD | (PEND & ~apply);
        pend_val_next = LD ? div_clamped : pend_val;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            cnt      <= '0;
            na       <= NA_RST;
            pend_val <= NA_RST;
            Z        <= 1'b0;
            ACT      <= 1'b0;
            PEND     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            na       <= na_next;
            pend_val <= pend_val_next;
            Z        <= z_next;
            ACT      <= act_next;
            PEND     <= pend_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv.sv
// ============================================================================
// Module  : tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv
// Purpose : Self-checking bench; expected Z is a queue of whole periods.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv;

    localparam int W       = 4;
    localparam int DIV_RST = 2;

    logic         CLK;
    logic         RN;
    logic         EN;
    logic         LD;
    logic [W-1:0] DIV;
    logic         Z;
    logic         ACT;
    logic         PEND;

    int errors;
    int checks;

    // Reference: one queue entry per clock of the current period.
    bit zq[$];
    int m_na;
    int m_pval;
    bit m_pend;
    bit m_running;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv #(
        .W       (W),
        .DIV_RST (DIV_RST)
    ) dut (
        .CLK  (CLK),
        .RN   (RN),
        .EN   (EN),
        .LD   (LD),
        .DIV  (DIV),
        .Z    (Z),
        .ACT  (ACT),
        .PEND (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        zq.delete();
        m_na      = DIV_RST;
        m_pval    = DIV_RST;
        m_pend    = 1'b0;
        m_running = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int div);
        if (zq.size() == 0) begin
            if ((m_running || en) && m_pend) begin
                m_na   = m_pval;
                m_pend = 1'b0;
            end
            if (en) begin
                for (int i = 0; i < m_na; i++) zq.push_back(i < (m_na / 2));
                m_running = 1'b1;
            end else begin
                m_running = 1'b0;
            end
        end
        if (ld) begin
            m_pend = 1'b1;
            m_pval = (div < 2) ? 2 : div;
        end
    endtask

    task automatic step(input bit en, input bit ld, input int div, input string tag);
        bit ez;
        EN  = en;
        LD  = ld;
        DIV = W'(div);
        @(posedge CLK);
        model_edge(en, ld, div);
        ez = (zq.size() != 0) ? zq.pop_front() : 1'b0;
        #1;
        checks++;
        if (Z !== ez) begin
            errors++;
            $display("FAIL %s z: got %b want %b at %0t", tag, Z, ez, $time);
        end
        checks++;
        if (ACT !== m_running) begin
            errors++;
            $display("FAIL %s act: got %b want %b at %0t", tag, ACT, m_running, $time);
        end
        checks++;
        if (PEND !== m_pend) begin
            errors++;
            $display("FAIL %s pend: got %b want %b at %0t", tag, PEND, m_pend, $time);
        end
        LD = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if ({Z, ACT, PEND} !== 3'b000) begin
            errors++;
            $display("FAIL %s z/act/pend: got %b%b%b want 000", tag, Z, ACT, PEND);
        end
    endtask

    task automatic test_reset();
        RN  = 1'b0;
        EN  = 1'b0;
        LD  = 1'b0;
        DIV = '0;
        #3;
        check_cleared("reset");
        @(posedge CLK);
        #2;
        RN = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, "idle_after_reset");
    endtask

    task automatic test_div2();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, "div2");
    endtask

    task automatic test_idle_load();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, "drain");
        step(1'b0, 1'b1, 5, "idle_ld5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, "idle_pend");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 0, "run5");
    endtask

    task automatic test_midload();
        // Align to a period start (cnt=0), then load 3 at cnt=1.
        while (zq.size() != 0) step(1'b1, 1'b0, 0, "align");
        step(1'b1, 1'b0, 0, "mid_cnt0");
        step(1'b1, 1'b1, 3, "mid_ld3");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, "run3");
    endtask

    task automatic test_stop_resume();
        while (zq.size() != 0) step(1'b1, 1'b0, 0, "align");
        step(1'b1, 1'b1, 4, "ld4");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, "run4");
        while (zq.size() != 0) step(1'b1, 1'b0, 0, "align4");
        step(1'b1, 1'b0, 0, "stop_cnt0");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, "stopping");
        step(1'b1, 1'b0, 0, "restart");
        step(1'b1, 1'b0, 0, "resume_cnt1");
        step(1'b0, 1'b0, 0, "resume_drop");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, "resume_run");
    endtask

    task automatic test_clamp_overwrite();
        step(1'b1, 1'b1, 0, "ld0");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, "clamp0");
        step(1'b1, 1'b1, 1, "ld1");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, "clamp1");
        step(1'b1, 1'b1, 7, "ld7");
        step(1'b1, 1'b1, 6, "ld6");
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0, "run6");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 15)), "random");
        end
    endtask

    task automatic test_async_reset();
        while (zq.size() != 0) step(1'b1, 1'b0, 0, "align");
        step(1'b1, 1'b1, 6, "ld6_async");
        while (zq.size() != 0) step(1'b1, 1'b0, 0, "align6");
        step(1'b1, 1'b1, 9, "high6_ld");
        step(1'b1, 1'b0, 0, "high6");
        #2;
        RN = 1'b0;
        #1;
        check_cleared("async_reset");
        model_reset();
        @(posedge CLK);
        #2;
        check_cleared("held_reset");
        RN = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, "post_rst_idle");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, "post_rst_div2");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();
        test_reset();
        test_div2();
        test_idle_load();
        test_midload();
        test_stop_resume();
        test_clamp_overwrite();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
